// File: rtl/pipe_pkg.sv
// Shared constants, types and hazard helper for the 5-stage pipeline control.
package pipe_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] TUSE_NONE    = 2'd3;
  localparam logic [1:0] TNEW_ALU     = 2'd1;
  localparam logic [1:0] TNEW_LOAD    = 2'd2;
  localparam logic [1:0] TNEW_MD_MOVE = 2'd1;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source operand hazards when a producer in E or M will not have its
  // result forwardable by the time the consumer in D needs it.
  function automatic logic src_hazard(
    input logic [REG_W-1:0] src,
    input logic [1:0]       tuse,
    input logic [REG_W-1:0] e_wa,
    input logic [1:0]       e_tnew,
    input logic [REG_W-1:0] m_wa,
    input logic [1:0]       m_tnew
  );
    if (src == REG_ZERO || tuse == TUSE_NONE) return 1'b0;
    return ((src == e_wa) && (e_tnew > tuse)) ||
           ((src == m_wa) && (m_tnew > tuse));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multi-cycle mult/div busy countdown with sticky overlap error flag.
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             hold_i,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] md_cnt_o,
  output logic             md_err_o
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          // A start during a freeze is retried by the pipeline, so not taken here.
          if (start_i && !hold_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          end
        end
        MD_BUSY: begin
          if (start_i) err_q <= 1'b1;
          if (!hold_i) begin
            if (cnt_q == CNT_W'(1)) begin
              state_q <= MD_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);
  assign md_cnt_o  = cnt_q;
  assign md_err_o  = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/freeze sequencer: D-stage hazard detect, md busy tracking, stage enables.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  input  logic             mem_wait,
  output logic             F_en,
  output logic             D_en,
  output logic             E_en,
  output logic             M_en,
  output logic             W_en,
  output logic             E_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_cnt,
  output logic             md_err
);

  logic        hz_rs, hz_rt, hz_md, stall;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk       (clk),
    .reset     (reset),
    .start_i   (E_md_start),
    .div_i     (E_md_div),
    .hold_i    (mem_wait),
    .md_busy_o (md_busy),
    .md_cnt_o  (md_cnt),
    .md_err_o  (md_err)
  );

  assign hz_rs = src_hazard(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
  assign hz_rt = src_hazard(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
  assign hz_md = D_md && (md_busy || E_md_start);
  assign stall = hz_rs || hz_rt || hz_md;

  // Reset beats freeze beats stall; a stall holds F/D and bubbles into E.
  always_comb begin
    F_en    = 1'b1;
    D_en    = 1'b1;
    E_en    = 1'b1;
    M_en    = 1'b1;
    W_en    = 1'b1;
    E_flush = 1'b0;
    if (!reset || mem_wait) begin
      F_en = 1'b0;
      D_en = 1'b0;
      E_en = 1'b0;
      M_en = 1'b0;
      W_en = 1'b0;
    end else if (stall) begin
      F_en    = 1'b0;
      D_en    = 1'b0;
      E_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !mem_wait) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/freeze sequencer for the 5-stage pipeline. Drives the enables of the F (PC), IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the ID/EX bubble (flush).
- Detects Tuse/Tnew data hazards in the D stage that forwarding cannot cover.
- Owns the multi-cycle mult/div busy timer.
- Honours a global memory-wait freeze.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu start
DIV_CYC, 10, busy cycles after a div/divu start
CNT_W, 4, md countdown width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
D_rs  in  5  rs field of instruction in D
D_rt  in  5  rt field of instruction in D
D_tuse_rs  in  2  Tuse of rs (0..2); 3 = not read
D_tuse_rt  in  2  Tuse of rt (0..2); 3 = not read
D_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_wa  in  5  destination register of E instruction (0 = none)
E_tnew  in  2  cycles until E result is forwardable
M_wa  in  5  destination register of M instruction
M_tnew  in  2  cycles until M result is forwardable
E_md_start  in  1  E holds mult/div this cycle (one-cycle pulse per instruction)
E_md_div  in  1  1 = div/divu, 0 = mult/multu; valid with E_md_start
mem_wait  in  1  data memory not ready; freeze whole pipeline
F_en  out  1  PC enable
D_en  out  1  IF/ID enable
E_en  out  1  ID/EX enable
M_en  out  1  EX/MEM enable
W_en  out  1  MEM/WB enable
E_flush  out  1  load bubble (zero instruction) into ID/EX
md_busy  out  1  mult/div unit busy (registered)
md_cnt  out  CNT_W  remaining busy cycles (registered)
stall_cnt  out  32  total stall cycles since reset, wraps at 2^32
md_err  out  1  sticky: E_md_start arrived while md_busy

Behaviour:
- Combinational hazard, same cycle:
  - hz_rs = D_rs!=0 && ((D_rs==E_wa && E_tnew>D_tuse_rs) || (D_rs==M_wa && M_tnew>D_tuse_rs)).
  - hz_rt is the same expression using rt.
  - D_tuse=3 never hazards.
- md hazard: hz_md = D_md && (md_busy || E_md_start).
- stall = hz_rs | hz_rt | hz_md.
- Priority 1: reset low. All *_en=0, E_flush=0.
- Priority 2: mem_wait=1. All *_en=0, E_flush=0; freeze wins over stall.
- Priority 3: stall=1. F_en=0, D_en=0, E_en=1, E_flush=1, M_en=1, W_en=1.
- Otherwise: all *_en=1, E_flush=0.
- md timer FSM states:
  - IDLE: md_busy=0, md_cnt=0.
  - BUSY: md_busy=1, md_cnt>0.
- IDLE -> BUSY: on an edge with E_md_start=1 and mem_wait=0. md_cnt loads DIV_CYC if E_md_div, else MULT_CYC. So busy is high from cycle t+1 through t+N.
- BUSY: md_cnt decrements each edge unless mem_wait=1 (count holds). At md_cnt==1 the next edge goes to IDLE with md_cnt=0.
- E_md_start while BUSY: ignored (no reload), md_err<=1. md_err clears only on reset.
- E_md_start while mem_wait=1: not accepted. The instruction stays in E and re-pulses; the bench holds E_md_start.
- stall_cnt increments on an edge when stall=1 and mem_wait=0 and reset is high.
- Reset values: md_busy=0, md_cnt=0, stall_cnt=0, md_err=0, FSM=IDLE.
- Reset asserted mid-BUSY aborts the count immediately (asynchronous).

Decomposition:
- Shared package pipe_pkg holds:
  - TUSE_NONE=2'd3.
  - Tnew encodings for ALU/load/md-move.
  - MULT_CYC/DIV_CYC defaults.
  - Register 0 constant.
- One natural sub-module, md_busy_timer. It owns the FSM, md_cnt, md_busy and md_err; inputs are start/div/hold.

Test Plan:
- Load-use: E_wa=5, E_tnew=2 (lw), D_rs=5, D_tuse_rs=1 -> F_en=0, D_en=0, E_flush=1, stall_cnt +1 per cycle. Next cycle E_tnew=0 -> all en=1, E_flush=0.
- $0 and no-read cases:
  - D_rs=0=E_wa with E_tnew=2 -> no stall.
  - D_tuse_rt=3 with D_rt==M_wa and M_tnew=1 -> no stall.
- Mult timing: E_md_start=1, E_md_div=0 at cycle 0 -> md_busy=1 cycles 1-5, md_cnt 5,4,3,2,1, then 0 in cycle 6. D_md=1 in cycles 0-5 stalls; cycle 6 passes.
- Div with freeze: div start, then mem_wait=1 for 3 cycles mid-count.
  - During mem_wait: md_cnt holds, all *_en=0, E_flush=0, stall_cnt unchanged.
  - md_busy stays high for 13 cycles total.
- Error and reset: E_md_start while md_cnt=7 -> md_cnt continues 6, md_err=1. Then reset=0 asynchronously mid-count -> md_busy=0, md_cnt=0, md_err=0, stall_cnt=0 without waiting for a clock edge.
